bec_wb_regs: RTL and testbench

Wishbone classic responder that lets the management SoC drive the binary-Edwards-curve (BEC) point-multiplication core inside the user project area. It is the slave end of the `wbs_*` bus that the user project wrapper passes through from Caravel. It holds the 163-bit key and point operands, issues a start pulse to the core, and captures the result when the core reports completion. It supervises the run with a timeout counter and raises a user interrupt on completion.

---
 rtl/bec_wb_regs.sv | 212 +++++++++++++++++++++
 tb/tb_bec_wb_regs.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bec_wb_regs.sv
// Wishbone classic register window for the BEC point-multiplication core.
// Holds the key/point operands, launches and aborts runs, captures the
// result and supervises each run with a busy-cycle timeout.
module bec_wb_regs #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic         irq_o,
  output logic         core_start_o,
  output logic         core_abort_o,
  output logic [162:0] core_key_o,
  output logic [162:0] core_pt_o,
  input  logic         core_done_i,
  input  logic [162:0] core_res_i
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam bit          TO_EN   = (TIMEOUT_CYC != 0);

  logic         ack_q, ack_d;
  logic [31:0]  dat_q, dat_d;
  logic         start_q, start_d;
  logic         abort_q, abort_d;
  logic         irq_en_q, irq_en_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         tout_q, tout_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [162:0] key_q, key_d;
  logic [162:0] pt_q, pt_d;
  logic [162:0] res_q, res_d;

  logic         in_win, acc, wr;
  logic [5:0]   off;
  logic         hit_key, hit_pt, hit_res;
  logic [2:0]   kidx, pidx, ridx;
  logic [31:0]  wmask, rdata;
  logic         start_w, abort_w;
  logic         unused_adr;

  assign in_win     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc        = wbs_cyc_i & wbs_stb_i & ~ack_q & in_win;
  assign wr         = acc & wbs_we_i;
  assign off        = wbs_adr_i[7:2];
  assign unused_adr = ^wbs_adr_i[1:0];

  assign hit_key = (off >= 6'd4)  && (off <= 6'd9);
  assign hit_pt  = (off >= 6'd12) && (off <= 6'd17);
  assign hit_res = (off >= 6'd20) && (off <= 6'd25);
  assign kidx    = 3'(off - 6'd4);
  assign pidx    = 3'(off - 6'd12);
  assign ridx    = 3'(off - 6'd20);

  assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                  {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  assign start_w = wr && (off == 6'd0) && wbs_sel_i[0] && wbs_dat_i[0];
  assign abort_w = wr && (off == 6'd0) && wbs_sel_i[0] && wbs_dat_i[2];

  // Word 5 of each 163-bit operand carries only bits 162:160.
  function automatic logic [31:0] word_of(input logic [162:0] v, input logic [2:0] i);
    logic [31:0] w;
    case (i)
      3'd0:    w = v[31:0];
      3'd1:    w = v[63:32];
      3'd2:    w = v[95:64];
      3'd3:    w = v[127:96];
      3'd4:    w = v[159:128];
      default: w = {29'b0, v[162:160]};
    endcase
    return w;
  endfunction

  function automatic logic [162:0] put_word(input logic [162:0] v, input logic [2:0] i,
                                            input logic [31:0] d, input logic [31:0] m);
    logic [162:0] r;
    r = v;
    case (i)
      3'd0:    r[31:0]    = (v[31:0]    & ~m) | (d & m);
      3'd1:    r[63:32]   = (v[63:32]   & ~m) | (d & m);
      3'd2:    r[95:64]   = (v[95:64]   & ~m) | (d & m);
      3'd3:    r[127:96]  = (v[127:96]  & ~m) | (d & m);
      3'd4:    r[159:128] = (v[159:128] & ~m) | (d & m);
      3'd5:    r[162:160] = (v[162:160] & ~m[2:0]) | (d[2:0] & m[2:0]);
      default: r = v;
    endcase
    return r;
  endfunction

  // Read mux over the register map; unmapped offsets read zero.
  always_comb begin
    rdata = '0;
    if (off == 6'd0)      rdata = {30'b0, irq_en_q, 1'b0};
    else if (off == 6'd1) rdata = {28'b0, tout_q, err_q, done_q, busy_q};
    else if (hit_key)     rdata = word_of(key_q, kidx);
    else if (hit_pt)      rdata = word_of(pt_q, pidx);
    else if (hit_res)     rdata = word_of(res_q, ridx);
  end

  // Next-state: bus response, register writes, run control and timeout.
  always_comb begin
    ack_d    = acc;
    dat_d    = (acc && !wbs_we_i) ? rdata : '0;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    irq_en_d = irq_en_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    tout_d   = tout_q;
    cnt_d    = busy_q ? cnt_q + 32'd1 : cnt_q;
    key_d    = key_q;
    pt_d     = pt_q;
    res_d    = res_q;

    if (wr && (off == 6'd0) && wbs_sel_i[0]) irq_en_d = wbs_dat_i[1];

    if (wr && (off == 6'd1)) begin
      if (wbs_dat_i[1]) done_d = 1'b0;
      if (wbs_dat_i[2]) err_d  = 1'b0;
      if (wbs_dat_i[3]) tout_d = 1'b0;
    end

    if (wr && hit_key) begin
      if (busy_q) err_d = 1'b1;
      else        key_d = put_word(key_q, kidx, wbs_dat_i, wmask);
    end

    if (wr && hit_pt) begin
      if (busy_q) err_d = 1'b1;
      else        pt_d  = put_word(pt_q, pidx, wbs_dat_i, wmask);
    end

    // Flag sets come after the W1C clears so a coincident set wins;
    // done beats abort and timeout within the same cycle.
    if (busy_q) begin
      if (start_w) err_d = 1'b1;
      if (core_done_i) begin
        res_d  = core_res_i;
        busy_d = 1'b0;
        done_d = 1'b1;
      end else if (abort_w) begin
        abort_d = 1'b1;
        busy_d  = 1'b0;
      end else if (TO_EN && (cnt_q == TO_LAST)) begin
        abort_d = 1'b1;
        busy_d  = 1'b0;
        tout_d  = 1'b1;
      end
    end else if (start_w) begin
      start_d = 1'b1;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b0;
      tout_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      irq_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
      cnt_q    <= '0;
      key_q    <= '0;
      pt_q     <= '0;
      res_q    <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      irq_en_q <= irq_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tout_q   <= tout_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      pt_q     <= pt_d;
      res_q    <= res_d;
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign irq_o        = done_q & irq_en_q;
  assign core_start_o = start_q;
  assign core_abort_o = abort_q;
  assign core_key_o   = key_q;
  assign core_pt_o    = pt_q;

endmodule

// File: tb/tb_bec_wb_regs.sv
// Self-checking bench for bec_wb_regs: directed scenarios plus randomized
// bus traffic checked against a word-level reference model.
module tb_bec_wb_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]   sel = '0;
  logic [31:0]  adr = '0, wdat = '0;
  logic         core_done = 1'b0, core_done16 = 1'b0;
  logic [162:0] core_res = '0;

  logic         ack, ack16, irq, irq16, st, st16, ab, ab16;
  logic [31:0]  rdat, rdat16;
  logic [162:0] key, key16, pt, pt16;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  logic [31:0] xfer_rd, xfer_rd16;
  logic        xfer_st, xfer_st16;
  int          start_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  bec_wb_regs dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .irq_o(irq), .core_start_o(st), .core_abort_o(ab),
    .core_key_o(key), .core_pt_o(pt),
    .core_done_i(core_done), .core_res_i(core_res)
  );

  bec_wb_regs #(.BASE_ADDR(BASE), .TIMEOUT_CYC(16)) dut16 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack16), .wbs_dat_o(rdat16),
    .irq_o(irq16), .core_start_o(st16), .core_abort_o(ab16),
    .core_key_o(key16), .core_pt_o(pt16),
    .core_done_i(core_done16), .core_res_i(core_res)
  );

  // ---------------- reference model (word-level) ----------------
  logic [31:0] m_key [6];
  logic [31:0] m_pt  [6];
  logic [31:0] m_res [6];
  logic m_irq_en, m_busy, m_done, m_err, m_tout;
  logic m_exp_start, m_exp_abort;

  task automatic m_reset();
    for (int i = 0; i < 6; i++) begin
      m_key[i] = '0; m_pt[i] = '0; m_res[i] = '0;
    end
    m_irq_en = 0; m_busy = 0; m_done = 0; m_err = 0; m_tout = 0;
    m_exp_start = 0; m_exp_abort = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s, input int widx);
    logic [31:0] m;
    logic [31:0] r;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    r = (old & ~m) | (d & m);
    if (widx == 5) r = r & 32'h7;
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int w);
    if (w == 0) return {30'b0, m_irq_en, 1'b0};
    if (w == 1) return {28'b0, m_tout, m_err, m_done, m_busy};
    if (w >= 4  && w <= 9)  return m_key[w-4];
    if (w >= 12 && w <= 17) return m_pt[w-12];
    if (w >= 20 && w <= 25) return m_res[w-20];
    return 32'h0;
  endfunction

  function automatic logic [162:0] m_keyvec();
    return {m_key[5][2:0], m_key[4], m_key[3], m_key[2], m_key[1], m_key[0]};
  endfunction

  function automatic logic [162:0] m_ptvec();
    return {m_pt[5][2:0], m_pt[4], m_pt[3], m_pt[2], m_pt[1], m_pt[0]};
  endfunction

  task automatic m_take_res(input logic [162:0] r);
    for (int i = 0; i < 5; i++) m_res[i] = r[32*i +: 32];
    m_res[5] = {29'b0, r[162:160]};
  endtask

  // One accepted bus access, optionally coinciding with a core_done pulse.
  task automatic m_apply(input logic w_en, input int w, input logic [31:0] d,
                         input logic [3:0] s, input logic dd, input logic [162:0] r);
    logic was_busy, st_req, ab_req;
    was_busy = m_busy;
    st_req = 0; ab_req = 0;
    m_exp_start = 0; m_exp_abort = 0;
    if (w_en) begin
      if (w == 0 && s[0]) begin
        m_irq_en = d[1]; st_req = d[0]; ab_req = d[2];
      end
      if (w == 1) begin
        if (d[1]) m_done = 0;
        if (d[2]) m_err  = 0;
        if (d[3]) m_tout = 0;
      end
      if (w >= 4 && w <= 9) begin
        if (was_busy) m_err = 1; else m_key[w-4] = merge(m_key[w-4], d, s, w-4);
      end
      if (w >= 12 && w <= 17) begin
        if (was_busy) m_err = 1; else m_pt[w-12] = merge(m_pt[w-12], d, s, w-12);
      end
    end
    if (was_busy) begin
      if (st_req) m_err = 1;
      if (dd) begin
        m_take_res(r); m_busy = 0; m_done = 1;
      end else if (ab_req) begin
        m_busy = 0; m_exp_abort = 1;
      end
    end else if (st_req) begin
      m_busy = 1; m_done = 0; m_err = 0; m_tout = 0; m_exp_start = 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [162:0] rnd163();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[162:0];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single Wishbone access. Entered and left 1 time unit after a rising edge.
  task automatic wb_xfer(input logic w_en, input int w, input logic [31:0] d,
                         input logic [3:0] s, input logic dd, input logic [162:0] r);
    logic [31:0] exp_rd;
    int k;
    exp_rd = m_read(w);
    cyc = 1; stb = 1; we = w_en; sel = s; wdat = d;
    adr = BASE | {24'b0, 6'(w), 2'($urandom_range(0, 3))};
    core_done = dd; core_res = r;
    @(posedge clk); #1;
    core_done = 0;
    k = 0;
    while (!ack && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ack_latency", k, 0);
    xfer_rd = rdat; xfer_rd16 = rdat16;
    xfer_st = st;   xfer_st16 = st16;
    if (st16) start_cyc = cyc_cnt;
    m_apply(w_en, w, d, s, dd, r);
    if (!w_en) chk($sformatf("rdata_w%0d", w), xfer_rd, exp_rd);
    chk("start_at_ack", st, m_exp_start);
    chk("abort_at_ack", ab, m_exp_abort);
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    chk("ack_one_cycle", ack, 0);
    chk("dat_zero_idle", rdat, 0);
    chk("start_single", st, 0);
    chk("abort_single", ab, 0);
  endtask

  task automatic wr32(input int w, input logic [31:0] d, input logic [3:0] s);
    wb_xfer(1'b1, w, d, s, 1'b0, '0);
  endtask

  task automatic rd32(input int w);
    wb_xfer(1'b0, w, 32'h0, 4'hF, 1'b0, '0);
  endtask

  task automatic pulse_done(input logic [162:0] r);
    core_done = 1; core_res = r;
    @(posedge clk); #1;
    core_done = 0;
    if (m_busy) begin
      m_take_res(r); m_busy = 0; m_done = 1;
    end
    chk("irq_after_done", irq, m_done & m_irq_en);
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    m_reset();
  endtask

  initial begin
    logic [162:0] rv;
    int k;
    m_reset();
    start_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_irq", irq, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_key", key, 0);
    chk("rst_pulses", {st, ab}, 0);
    rst_n = 1;
    idle(1);

    // Operand round trip
    wr32(9, 32'hFFFF_FFFF, 4'hF);
    wr32(12, 32'hA5A5_A5A5, 4'b0011);
    rd32(9);  chk("key5_read", xfer_rd, 32'h7);
    rd32(12); chk("pt0_read", xfer_rd, 32'h0000_A5A5);
    chk("key_o_top", key[162:160], 3'b111);

    // Normal run
    wr32(0, 32'h2, 4'hF);
    wr32(0, 32'h3, 4'hF);
    chk("start_pulse", xfer_st, 1);
    idle(100);
    pulse_done(163'h1);
    rd32(20); chk("res0", xfer_rd, 32'h1);
    rd32(1);  chk("status_done", xfer_rd, 32'h2);
    chk("irq_set", irq, 1);
    wr32(1, 32'h2, 4'hF);
    chk("irq_clear", irq, 0);

    // Error cases
    wr32(0, 32'h3, 4'hF);
    chk("start2", xfer_st, 1);
    wr32(0, 32'h3, 4'hF);
    chk("no_restart", xfer_st, 0);
    wr32(4, 32'h1234_5678, 4'hF);
    rd32(4);  chk("key0_locked", xfer_rd, 32'h0);
    rd32(1);  chk("status_err", xfer_rd, 32'h5);
    rv = rnd163();
    wb_xfer(1'b1, 1, 32'h2, 4'hF, 1'b1, rv);
    rd32(1);  chk("done_set_wins", xfer_rd, 32'h6);
    chk("irq_err_case", irq, 1);

    // Reset during an in-flight transfer
    cyc = 1; stb = 1; we = 0; adr = BASE | 32'h10;
    @(posedge clk); #1;
    chk("inflight_ack", ack, 1);
    #2 rst_n = 0;
    #1;
    chk("async_ack", ack, 0);
    chk("async_irq", irq, 0);
    chk("async_dat", rdat, 0);
    chk("async_ops", {key, pt}, 0);
    cyc = 0; stb = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_late_ack", ack, 0);
    end
    rd32(1); chk("status_post_rst", xfer_rd, 32'h0);
    rd32(4); chk("key0_post_rst", xfer_rd, 32'h0);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      logic dd;
      int op, w;
      dd = ($urandom_range(0, 7) == 0);
      rv = rnd163();
      op = $urandom_range(0, 9);
      case (op)
        0, 1: begin
          w = ($urandom_range(0, 1) != 0) ? $urandom_range(4, 9) : $urandom_range(12, 17);
          wb_xfer(1'b1, w, $urandom, 4'($urandom), dd, rv);
        end
        2: wb_xfer(1'b1, 0, $urandom, 4'($urandom), dd, rv);
        3: wb_xfer(1'b1, 1, $urandom, 4'hF, dd, rv);
        4, 5, 6: wb_xfer(1'b0, $urandom_range(0, 63), 32'h0, 4'hF, dd, rv);
        7: pulse_done(rv);
        8: idle($urandom_range(0, 5));
        default: wb_xfer(1'b1, $urandom_range(0, 63), $urandom, 4'($urandom), dd, rv);
      endcase
      chk("rnd_irq", irq, m_done & m_irq_en);
      chk("rnd_key_o", key, m_keyvec());
      chk("rnd_pt_o", pt, m_ptvec());
    end

    // Timeout on the 16-cycle instance
    do_reset();
    idle(1);
    wr32(0, 32'h1, 4'hF);
    chk("t16_start", xfer_st16, 1);
    k = 0;
    while (!ab16 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t16_abort_delay", cyc_cnt - start_cyc, 16);
    @(posedge clk); #1;
    chk("t16_abort_single", ab16, 0);
    rd32(1);  chk("t16_status", xfer_rd16, 32'h8);
    core_done16 = 1; core_res = rnd163();
    @(posedge clk); #1;
    core_done16 = 0;
    rd32(20); chk("t16_res_kept", xfer_rd16, 32'h0);
    rd32(1);  chk("t16_status_kept", xfer_rd16, 32'h8);

    // Address decode
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h100;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack || ack16) k++;
    end
    chk("out_of_window", k, 0);
    cyc = 0; stb = 0;
    idle(1);
    rd32(60); chk("unmapped_f0", xfer_rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
